// File: rtl/burst_fifo_pkg.sv
// Shared video-path width constants used as defaults for the pixel FIFO.
package burst_fifo_pkg;
    localparam int PIXEL_W = 24;
    localparam int FIFO_AW = 8;
endpackage

// File: rtl/burst_fifo_mem.sv
// LEN x DW simple dual-port storage: synchronous write, asynchronous read,
// shaped to map onto distributed RAM.
module fifo_mem
    import burst_fifo_pkg::*;
#(
    parameter int DW = PIXEL_W,
    parameter int AW = FIFO_AW
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    localparam int LEN = 2 ** AW;

    logic [DW-1:0] mem [LEN];

    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/burst_fifo.sv
// Single-clock pixel FIFO with explicit occupancy counter, burst thresholds,
// synchronous flush and sticky overflow/underflow flags.
module burst_fifo
    import burst_fifo_pkg::*;
#(
    parameter int DW        = PIXEL_W,
    parameter int AW        = FIFO_AW,
    parameter int BURST_LEN = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          in_incr_i,
    input  logic [DW-1:0] in_data_i,
    output logic          in_rdy_o,
    input  logic          out_incr_i,
    output logic [DW-1:0] out_data_o,
    output logic          out_val_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o,
    output logic          ovf_o,
    output logic          udf_o
);
    localparam logic [AW:0] LEN_L   = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] BURST_L = (AW+1)'(BURST_LEN);

    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   level;
    logic          pop_acc, push_acc;

    // The pop is decided first so a full FIFO can accept a simultaneous push;
    // an empty FIFO never bypasses, so its pop is rejected.
    assign pop_acc  = out_incr_i && (level != '0);
    assign push_acc = in_incr_i && ((level != LEN_L) || pop_acc);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            ovf_o <= 1'b0;
            udf_o <= 1'b0;
        end else if (flush_i) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            ovf_o <= 1'b0;
            udf_o <= 1'b0;
        end else begin
            if (push_acc) wptr <= wptr + AW'(1);
            if (pop_acc)  rptr <= rptr + AW'(1);
            case ({push_acc, pop_acc})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
            if (in_incr_i && !push_acc) ovf_o <= 1'b1;
            if (out_incr_i && !pop_acc) udf_o <= 1'b1;
        end
    end

    fifo_mem #(.DW(DW), .AW(AW)) u_mem (
        .clk_i   (clk_i),
        .we_i    (push_acc && !flush_i),
        .waddr_i (wptr),
        .wdata_i (in_data_i),
        .raddr_i (rptr),
        .rdata_o (out_data_o)
    );

    assign in_rdy_o  = (LEN_L - level) >= BURST_L;
    assign out_val_o = level >= BURST_L;
    assign full_o    = level == LEN_L;
    assign empty_o   = level == '0;
    assign level_o   = level;
endmodule

// File: tb/tb_burst_fifo.sv
// Self-checking bench for burst_fifo: directed scenarios followed by a long
// randomized run, all compared against a queue-based reference model.
module tb_burst_fifo;
    localparam int DW  = 24;
    localparam int AW  = 8;
    localparam int BL  = 16;
    localparam int LEN = 256;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          flush_i = 1'b0;
    logic          in_incr_i = 1'b0;
    logic [DW-1:0] in_data_i = '0;
    logic          out_incr_i = 1'b0;
    logic          in_rdy_o, out_val_o, full_o, empty_o, ovf_o, udf_o;
    logic [DW-1:0] out_data_o;
    logic [AW:0]   level_o;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] q[$];
    bit            m_ovf = 1'b0;
    bit            m_udf = 1'b0;

    always #5 clk_i = ~clk_i;

    burst_fifo #(.DW(DW), .AW(AW), .BURST_LEN(BL)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .in_incr_i  (in_incr_i),
        .in_data_i  (in_data_i),
        .in_rdy_o   (in_rdy_o),
        .out_incr_i (out_incr_i),
        .out_data_o (out_data_o),
        .out_val_o  (out_val_o),
        .full_o     (full_o),
        .empty_o    (empty_o),
        .level_o    (level_o),
        .ovf_o      (ovf_o),
        .udf_o      (udf_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int lvl;
        lvl = q.size();
        chk("level",   32'(level_o),   32'(lvl));
        chk("empty",   32'(empty_o),   32'(lvl == 0));
        chk("full",    32'(full_o),    32'(lvl == LEN));
        chk("out_val", 32'(out_val_o), 32'(lvl >= BL));
        chk("in_rdy",  32'(in_rdy_o),  32'((LEN - lvl) >= BL));
        chk("ovf",     32'(ovf_o),     32'(m_ovf));
        chk("udf",     32'(udf_o),     32'(m_udf));
        if (lvl > 0) chk("data", 32'(out_data_o), 32'(q[0]));
    endtask

    // One clock with the given requests; the model applies the FIFO rules
    // (pop considered first, then push) to the pre-edge contents.
    task automatic cyc(input bit push, input logic [DW-1:0] d, input bit pop, input bit fl);
        bit pop_ok, push_ok;
        logic [DW-1:0] junk;
        in_incr_i  = push;
        in_data_i  = d;
        out_incr_i = pop;
        flush_i    = fl;
        @(posedge clk_i);
        if (fl) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            pop_ok  = pop && (q.size() > 0);
            if (pop_ok) junk = q.pop_front();
            push_ok = push && (q.size() < LEN);
            if (push_ok) q.push_back(d);
            if (push && !push_ok) m_ovf = 1'b1;
            if (pop && !pop_ok) m_udf = 1'b1;
        end
        #1 check_all();
    endtask

    task automatic reset_pulse();
        #2 rst_ni = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        #1 check_all();
        in_incr_i  = 1'b0;
        out_incr_i = 1'b0;
        flush_i    = 1'b0;
        @(negedge clk_i) rst_ni = 1'b1;
    endtask

    initial begin
        int pp, pq;
        #3 check_all();
        @(negedge clk_i) rst_ni = 1'b1;

        // First burst: 16 pushes raise out_val_o.
        for (int i = 1; i <= 16; i++) cyc(1'b1, 24'(i), 1'b0, 1'b0);
        chk("burst_val", 32'(out_val_o), 32'd1);
        chk("burst_head", 32'(out_data_o), 32'h000001);

        // Fill to full, then one dropped push.
        for (int i = 17; i <= LEN; i++) cyc(1'b1, 24'(i), 1'b0, 1'b0);
        cyc(1'b1, 24'hDEAD00, 1'b0, 1'b0);
        chk("full_ovf", 32'(ovf_o), 32'd1);

        // Clear, refill, then push+pop at full across pointer wrap.
        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < LEN; i++) cyc(1'b1, 24'(i + 24'h100), 1'b0, 1'b0);
        for (int i = 0; i < 200; i++) cyc(1'b1, 24'hABCDEF, 1'b1, 1'b0);

        // Drain, then push+pop while empty.
        for (int i = 0; i < LEN; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b1, 24'h123456, 1'b1, 1'b0);
        chk("empty_pp_data", 32'(out_data_o), 32'h123456);

        // Reach level 40 with ovf set, then flush together with a push.
        for (int i = 0; i < LEN; i++) cyc(1'b1, 24'(i * 7), 1'b0, 1'b0);
        for (int i = 0; i < LEN - 40; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        chk("pre_flush_ovf", 32'(ovf_o), 32'd1);
        cyc(1'b1, 24'h777777, 1'b0, 1'b1);
        chk("flush_level", 32'(level_o), 32'd0);

        // Randomized traffic with phased bias so both full and empty are hit.
        for (int c = 0; c < 10000; c++) begin
            case ((c / 700) % 3)
                0:       begin pp = 80; pq = 30; end
                1:       begin pp = 30; pq = 80; end
                default: begin pp = 60; pq = 60; end
            endcase
            cyc(($urandom_range(0, 99) < pp), 24'($urandom), ($urandom_range(0, 99) < pq),
                ($urandom_range(0, 499) == 0));
            if (c == 5000) reset_pulse();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
